// File: rtl/goboard_display_ctrl.sv
// goboard_display_ctrl: captures a byte, converts it to BCD with a sequential
// double-dabble, and schedules the two 7-segment digit nibbles (hex, decimal
// with leading-zero blanking, or paged decimal for values >= 100).
module goboard_display_ctrl #(
  parameter int DWELL_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] value_i,
  input  logic       load_i,
  input  logic       hex_mode_i,
  output logic [3:0] digit1_o,
  output logic [3:0] digit2_o,
  output logic       blank1_o,
  output logic       blank2_o,
  output logic       busy_o,
  output logic       page_o
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

  state_t        state, nextState;
  logic [7:0]    capByte, shiftReg, dispByte;
  logic [11:0]   bcd, bcdAdj, bcdNext;
  logic [3:0]    stepCnt, hund, tens, ones;
  logic [DW-1:0] dwell, dwellNext;
  logic          pageQ, pageNext, hexQ, hasRes;
  logic          done, modeChg, nHasRes;
  logic [7:0]    nByte;
  logic [3:0]    nHund, nTens, nOnes;
  logic [3:0]    d1Next, d2Next;
  logic          b1Next, b2Next, pgNext;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next state: a load always (re)starts conversion, otherwise CONV ends on step 8
  always_comb begin
    nextState = state;
    if (load_i)    nextState = CONV;
    else if (done) nextState = SHOW;
  end

  // Datapath next values: one double-dabble step, result landing, dwell/page
  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < 3; i++)
      if (bcd[i*4 +: 4] >= 4'd5) bcdAdj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    bcdNext = (bcdAdj << 1) | {11'b0, shiftReg[7]};
    done    = (state == CONV) && (stepCnt == 4'd7);
    modeChg = (hex_mode_i != hexQ);
    nHasRes = hasRes | done;
    nByte   = done ? capByte       : dispByte;
    nHund   = done ? bcdNext[11:8] : hund;
    nTens   = done ? bcdNext[7:4]  : tens;
    nOnes   = done ? bcdNext[3:0]  : ones;
    // Paging only runs while showing a three-digit decimal value; it is
    // frozen during a reconversion and restarted when a result lands.
    dwellNext = dwell;
    pageNext  = pageQ;
    if (done || modeChg || hex_mode_i || nHund == 4'd0) begin
      dwellNext = '0;
      pageNext  = 1'b0;
    end else if (state == SHOW) begin
      if (dwell == DWELL_MAX) begin
        dwellNext = '0;
        pageNext  = ~pageQ;
      end else begin
        dwellNext = dwell + 1'b1;
      end
    end
  end

  // Output decode from next-cycle result/mode/page; registered below
  always_comb begin
    d1Next = 4'd0;
    d2Next = 4'd0;
    b1Next = 1'b1;
    b2Next = 1'b1;
    pgNext = 1'b0;
    if (nHasRes) begin
      b2Next = 1'b0;
      if (hex_mode_i) begin
        d1Next = nByte[7:4];
        d2Next = nByte[3:0];
        b1Next = 1'b0;
      end else if (nHund == 4'd0) begin
        b1Next = (nTens == 4'd0);
        d1Next = nTens;
        d2Next = nOnes;
      end else if (!pageNext) begin
        d2Next = nHund;
      end else begin
        b1Next = 1'b0;
        d1Next = nTens;
        d2Next = nOnes;
        pgNext = 1'b1;
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      capByte  <= '0;
      shiftReg <= '0;
      dispByte <= '0;
      bcd      <= '0;
      stepCnt  <= '0;
      hund     <= '0;
      tens     <= '0;
      ones     <= '0;
      dwell    <= '0;
      pageQ    <= 1'b0;
      hexQ     <= 1'b0;
      hasRes   <= 1'b0;
      digit1_o <= '0;
      digit2_o <= '0;
      blank1_o <= 1'b1;
      blank2_o <= 1'b1;
      busy_o   <= 1'b0;
      page_o   <= 1'b0;
    end else begin
      hexQ <= hex_mode_i;
      if (load_i) begin
        capByte  <= value_i;
        shiftReg <= value_i;
        bcd      <= '0;
        stepCnt  <= '0;
      end else if (state == CONV) begin
        shiftReg <= shiftReg << 1;
        bcd      <= bcdNext;
        stepCnt  <= stepCnt + 4'd1;
      end
      hund     <= nHund;
      tens     <= nTens;
      ones     <= nOnes;
      dispByte <= nByte;
      hasRes   <= nHasRes;
      dwell    <= dwellNext;
      pageQ    <= pageNext;
      digit1_o <= d1Next;
      digit2_o <= d2Next;
      blank1_o <= b1Next;
      blank2_o <= b2Next;
      page_o   <= pgNext;
      busy_o   <= (nextState == CONV);
    end
  end

endmodule
